audio_mix_scheduler: RTL and testbench

- Sits between the HPS-fed per-voice sample buffers and the audio core's left/right Avalon-ST DAC sink in soc_system.
- Once per audio frame, services each voice in round-robin order and pulls at most one sample per enabled voice.
- Sums the samples, applies master attenuation, saturates, and pushes the same mono sample to both DAC channels.
- Paced entirely by the audio core's ready signals; counts voice underruns.

---
 rtl/audio_mix_pkg.sv | 40 ++++
 rtl/audio_mix_sat.sv | 22 ++
 rtl/audio_mix_scheduler.sv | 165 ++++++++++++++++
 tb/tb_audio_mix_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_mix_pkg.sv
// Shared types and helpers for the audio mix scheduler: frame FSM states,
// sample range limits and the clamp used after master attenuation.
package audio_mix_pkg;

    typedef enum logic [1:0] {
        START   = 2'd0,
        COLLECT = 2'd1,
        MIX     = 2'd2,
        OUTPUT  = 2'd3
    } mix_state_e;

    // Helpers work on a wide signed value so any DW/ACC_W pairing fits.
    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] sample_max(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sample_min(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

    // Clamp a sign-extended accumulator value into the dw-bit sample range.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] value,
        input int                      dw
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = sample_max(dw);
        lo = sample_min(dw);
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/audio_mix_sat.sv
// Master attenuation and saturation: arithmetic right shift of the frame sum
// followed by a clamp to the signed DW-bit sample range. Purely combinational.
module audio_mix_sat
    import audio_mix_pkg::*;
#(
    parameter int DW    = 16,
    parameter int ACC_W = 18
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic        [1:0]       shift_i,
    output logic signed [DW-1:0]    sample_o
);

    logic signed [ACC_W-1:0] shifted;

    // Shift keeps the sign, then the clamp folds overflowed sums to full scale.
    always_comb begin
        shifted  = acc_i >>> shift_i;
        sample_o = DW'(saturate(SAT_W'(shifted), DW));
    end

endmodule

// File: rtl/audio_mix_scheduler.sv
// Per-frame voice mixer feeding the audio core's left/right sinks.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   START   | latch enable mask and shift, clear accumulator and index
//   COLLECT | one cycle per voice, pull at most one sample, count misses
//   MIX     | shift + saturate the sum, load both output channels
//   OUTPUT  | hold each side until its sink accepts, then next frame
//
// The frame is paced only by the sink readies; a voice that has no sample
// in its slot contributes silence and is counted as an underrun.
module audio_mix_scheduler
    import audio_mix_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DW     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH*DW-1:0] ch_data,
    input  logic [NUM_CH-1:0]    ch_valid,
    output logic [NUM_CH-1:0]    ch_ready,
    input  logic [NUM_CH-1:0]    ch_enable,
    input  logic [1:0]           master_shift,
    output logic [DW-1:0]        left_data,
    output logic                 left_valid,
    input  logic                 left_ready,
    output logic [DW-1:0]        right_data,
    output logic                 right_valid,
    input  logic                 right_ready,
    input  logic                 underrun_clr,
    output logic [15:0]          underrun_cnt
);

    localparam int ACC_W = DW + $clog2(NUM_CH);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    mix_state_e              state_q;
    logic [NUM_CH-1:0]       en_q;
    logic [1:0]              sh_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic [IDX_W-1:0]        idx_q;
    logic [DW-1:0]           left_data_q;
    logic [DW-1:0]           right_data_q;
    logic                    left_valid_q;
    logic                    left_valid_d;
    logic                    right_valid_q;
    logic                    right_valid_d;
    logic [15:0]             underrun_q;
    logic [15:0]             underrun_d;

    logic signed [DW-1:0]    voice_sample;
    logic                    voice_en;
    logic                    voice_hit;
    logic                    voice_miss;
    logic signed [DW-1:0]    mix_sample;

    // Current voice slot: sample select, hit/miss decode and accumulator update.
    always_comb begin
        voice_en     = en_q[idx_q];
        voice_sample = $signed(ch_data[idx_q*DW +: DW]);
        voice_hit    = (state_q == COLLECT) && voice_en && ch_valid[idx_q];
        voice_miss   = (state_q == COLLECT) && voice_en && !ch_valid[idx_q];
        acc_d        = voice_hit ? (acc_q + ACC_W'(voice_sample)) : acc_q;
    end

    // Ready is a pure function of the slot, so a voice never waits on itself.
    always_comb begin
        ch_ready = '0;
        if (state_q == COLLECT) begin
            ch_ready[idx_q] = en_q[idx_q];
        end
    end

    // Each side releases its valid on its own handshake.
    always_comb begin
        left_valid_d  = left_valid_q && !left_ready;
        right_valid_d = right_valid_q && !right_ready;
    end

    audio_mix_sat #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_sat (
        .acc_i    (acc_q),
        .shift_i  (sh_q),
        .sample_o (mix_sample)
    );

    // Frame sequencer with registered channel outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= START;
            en_q          <= '0;
            sh_q          <= '0;
            acc_q         <= '0;
            idx_q         <= '0;
            left_data_q   <= '0;
            right_data_q  <= '0;
            left_valid_q  <= 1'b0;
            right_valid_q <= 1'b0;
        end else begin
            case (state_q)
                START: begin
                    en_q    <= ch_enable;
                    sh_q    <= master_shift;
                    acc_q   <= '0;
                    idx_q   <= '0;
                    state_q <= COLLECT;
                end
                COLLECT: begin
                    acc_q <= acc_d;
                    if (idx_q == LAST_IDX) begin
                        state_q <= MIX;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                MIX: begin
                    left_data_q   <= mix_sample;
                    right_data_q  <= mix_sample;
                    left_valid_q  <= 1'b1;
                    right_valid_q <= 1'b1;
                    state_q       <= OUTPUT;
                end
                OUTPUT: begin
                    left_valid_q  <= left_valid_d;
                    right_valid_q <= right_valid_d;
                    if (!left_valid_d && !right_valid_d) begin
                        state_q <= START;
                    end
                end
                default: state_q <= START;
            endcase
        end
    end

    // Clear wins over saturation; a miss in the clear cycle still counts once.
    always_comb begin
        underrun_d = underrun_q;
        if (underrun_clr) begin
            underrun_d = voice_miss ? 16'd1 : 16'd0;
        end else if (voice_miss && (underrun_q != 16'hFFFF)) begin
            underrun_d = underrun_q + 16'd1;
        end
    end

    // Underrun counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_q <= '0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign left_data    = left_data_q;
    assign right_data   = right_data_q;
    assign left_valid   = left_valid_q;
    assign right_valid  = right_valid_q;
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Scoreboard bench for audio_mix_scheduler (NUM_CH=4, DW=16).
// Stimulus pushes expected mix results and ch_ready slot order into queues;
// a monitor pops and compares on every sink handshake and ready pulse.
module tb_audio_mix_scheduler;

    logic        clk;
    logic        reset;
    logic [63:0] ch_data;
    logic [3:0]  ch_valid;
    logic [3:0]  ch_ready;
    logic [3:0]  ch_enable;
    logic [1:0]  master_shift;
    logic [15:0] left_data;
    logic        left_valid;
    logic        left_ready;
    logic [15:0] right_data;
    logic        right_valid;
    logic        right_ready;
    logic        underrun_clr;
    logic [15:0] underrun_cnt;

    int total;
    int passed;

    logic [15:0] exp_l[$];
    logic [15:0] exp_r[$];
    int          exp_rdy[$];
    time         last_t;
    time         prev_t;

    audio_mix_scheduler #(.NUM_CH(4), .DW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .ch_data      (ch_data),
        .ch_valid     (ch_valid),
        .ch_ready     (ch_ready),
        .ch_enable    (ch_enable),
        .master_shift (master_shift),
        .left_data    (left_data),
        .left_valid   (left_valid),
        .left_ready   (left_ready),
        .right_data   (right_data),
        .right_valid  (right_valid),
        .right_ready  (right_ready),
        .underrun_clr (underrun_clr),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        total++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] d0, input logic [15:0] d1,
                                          input logic [15:0] d2, input logic [15:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // Monitor: compares every handshake and every ready pulse against the queues.
    initial begin
        last_t = 0;
        prev_t = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (left_valid && left_ready) begin
                    if (exp_l.size() == 0) fail("left_unexpected", 32'(left_data));
                    else check("left_data", 32'(left_data), 32'(exp_l.pop_front()));
                    prev_t = last_t;
                    last_t = $time;
                end
                if (right_valid && right_ready) begin
                    if (exp_r.size() == 0) fail("right_unexpected", 32'(right_data));
                    else check("right_data", 32'(right_data), 32'(exp_r.pop_front()));
                end
                if (ch_ready != 4'b0000) begin
                    if (exp_rdy.size() == 0) fail("ch_ready_unexpected", 32'(ch_ready));
                    else check("ch_ready_order", 32'(ch_ready), 32'(1) << exp_rdy.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    // Called at posedge+1 with the DUT parked in OUTPUT: loads the next frame's
    // inputs and accepts the parked result with a one-cycle handshake.
    task automatic start_frame(input logic [63:0] data, input logic [3:0] valid,
                               input logic [3:0] en, input logic [1:0] sh,
                               input logic [15:0] req);
        ch_data      = data;
        ch_valid     = valid;
        ch_enable    = en;
        master_shift = sh;
        exp_l.push_back(req);
        exp_r.push_back(req);
        for (int i = 0; i < 4; i++) if (en[i]) exp_rdy.push_back(i);
        left_ready  = 1'b1;
        right_ready = 1'b1;
        @(posedge clk); #1;
        left_ready  = 1'b0;
        right_ready = 1'b0;
    endtask

    task automatic wait_park();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input int idx);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!found) begin
                @(negedge clk);
                if (ch_ready[idx]) found = 1'b1;
            end
        end
        if (!found) fail("wait_ch_ready_timeout", 32'(idx));
    endtask

    initial begin
        total        = 0;
        passed       = 0;
        reset        = 1'b1;
        ch_data      = '0;
        ch_valid     = '0;
        ch_enable    = '0;
        master_shift = '0;
        left_ready   = 1'b0;
        right_ready  = 1'b0;
        underrun_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_left_valid", 32'(left_valid), 0);
        check("rst_right_valid", 32'(right_valid), 0);
        check("rst_ch_ready", 32'(ch_ready), 0);
        check("rst_left_data", 32'(left_data), 0);
        check("rst_underrun", 32'(underrun_cnt), 0);

        // Frame 0: everything disabled, mixes to silence.
        exp_l.push_back(16'h0000);
        exp_r.push_back(16'h0000);
        reset = 1'b0;
        wait_park();

        // Back-to-back frames with both sinks always ready: 100+200-50+25 = 275.
        ch_data      = pack4(16'd100, 16'd200, 16'hFFCE, 16'd25);
        ch_valid     = 4'hF;
        ch_enable    = 4'hF;
        master_shift = 2'd0;
        for (int f = 0; f < 3; f++) begin
            exp_l.push_back(16'd275);
            exp_r.push_back(16'd275);
            for (int i = 0; i < 4; i++) exp_rdy.push_back(i);
        end
        left_ready  = 1'b1;
        right_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        left_ready  = 1'b0;
        right_ready = 1'b0;
        check("frame_period_ns", 32'(last_t - prev_t), 70);
        wait_park();

        // Saturation and attenuation corners.
        start_frame(pack4(16'h7000, 16'h7000, 16'h7000, 16'h7000), 4'hF, 4'hF, 2'd0, 16'h7FFF);
        wait_park();
        start_frame(pack4(16'h9000, 16'h9000, 16'h9000, 16'h9000), 4'hF, 4'hF, 2'd0, 16'h8000);
        wait_park();
        start_frame(pack4(16'h7000, 16'h7000, 16'h7000, 16'h7000), 4'hF, 4'hF, 2'd2, 16'h7000);
        wait_park();
        // -3 >>> 1 rounds toward minus infinity.
        start_frame(pack4(16'hFFFD, 16'h0000, 16'h0000, 16'h0000), 4'hF, 4'hF, 2'd1, 16'hFFFE);
        wait_park();
        check("underrun_none", 32'(underrun_cnt), 0);

        // Voice 2 starves for three frames: 100+200+25 = 325.
        for (int f = 0; f < 3; f++) begin
            start_frame(pack4(16'd100, 16'd200, 16'hFFCE, 16'd25), 4'b1011, 4'hF, 2'd0, 16'd325);
            wait_park();
        end
        check("underrun_three", 32'(underrun_cnt), 3);
        start_frame(pack4(16'd100, 16'd200, 16'hFFCE, 16'd25), 4'b1011, 4'hF, 2'd0, 16'd325);
        wait_rdy(2);
        underrun_clr = 1'b1;
        @(posedge clk); #1;
        underrun_clr = 1'b0;
        wait_park();
        check("underrun_clr_with_miss", 32'(underrun_cnt), 1);

        // Left sink stalls 10 cycles; right completes at once.
        ch_data      = pack4(16'd1000, 16'd2000, 16'd3000, 16'd4000);
        ch_valid     = 4'hF;
        ch_enable    = 4'hF;
        master_shift = 2'd0;
        exp_l.push_back(16'd10000);
        exp_r.push_back(16'd10000);
        for (int i = 0; i < 4; i++) exp_rdy.push_back(i);
        right_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("stall_left_valid", 32'(left_valid), 1);
            check("stall_left_data", 32'(left_data), 325);
            check("stall_no_ch_ready", 32'(ch_ready), 0);
            if (k >= 2) check("stall_right_valid", 32'(right_valid), 0);
        end
        @(posedge clk); #1;
        left_ready = 1'b1;
        @(posedge clk); #1;
        left_ready  = 1'b0;
        right_ready = 1'b0;
        wait_park();

        // Mask change mid-COLLECT only affects the following frame.
        start_frame(pack4(16'd10, 16'd20, 16'd30, 16'd40), 4'hF, 4'hF, 2'd0, 16'd100);
        wait_rdy(1);
        ch_enable = 4'b0001;
        wait_park();
        start_frame(pack4(16'd10, 16'd20, 16'd30, 16'd40), 4'hF, 4'b0001, 2'd0, 16'd10);
        wait_park();

        // Reset in the middle of COLLECT discards the frame.
        start_frame(pack4(16'd100, 16'd200, 16'hFFCE, 16'd25), 4'hF, 4'hF, 2'd0, 16'd275);
        wait_rdy(2);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_ch_ready", 32'(ch_ready), 0);
        check("midrst_left_valid", 32'(left_valid), 0);
        check("midrst_right_valid", 32'(right_valid), 0);
        check("midrst_left_data", 32'(left_data), 0);
        check("midrst_right_data", 32'(right_data), 0);
        check("midrst_underrun", 32'(underrun_cnt), 0);
        exp_l.delete();
        exp_r.delete();
        exp_rdy.delete();
        ch_data = pack4(16'd7, 16'd8, 16'd9, 16'd10);
        exp_l.push_back(16'd34);
        exp_r.push_back(16'd34);
        for (int i = 0; i < 4; i++) exp_rdy.push_back(i);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("postrst_underrun", 32'(underrun_cnt), 0);

        // Drain the last result with voices disabled so nothing else is pulled.
        ch_enable   = 4'b0000;
        left_ready  = 1'b1;
        right_ready = 1'b1;
        @(posedge clk); #1;
        left_ready  = 1'b0;
        right_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("queues_drained", 32'(exp_l.size() + exp_r.size() + exp_rdy.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
